// File: rtl/fnn_pkg.sv
// Shared fixed-point constants and state types for the neuron datapath blocks.
package fnn_pkg;
   localparam int FX_W    = 16;
   localparam int FX_FRAC = 8;
   localparam logic [FX_W-1:0] FX_ONE = FX_W'(1 << FX_FRAC);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_BIAS} wseq_state_t;
endpackage

// File: rtl/neuron_weight_seq_if.sv
// Activation stream, weight-memory read port and MAC beat bundle for neuron_weight_seq.
interface neuron_weight_seq_if #(
   parameter int addressWidth = 4,
   parameter int dataWidth    = fnn_pkg::FX_W
);
   logic                    in_valid;
   logic [dataWidth-1:0]    in_data;
   logic                    in_ready;
   logic                    mem_ren;
   logic [addressWidth-1:0] mem_radd;
   logic [dataWidth-1:0]    mem_wout;
   logic                    mac_valid;
   logic [dataWidth-1:0]    mac_w;
   logic [dataWidth-1:0]    mac_x;
   logic                    mac_last;

   modport master (
      input  in_valid, in_data, mem_wout,
      output in_ready, mem_ren, mem_radd, mac_valid, mac_w, mac_x, mac_last
   );
   modport slave (
      output in_valid, in_data, mem_wout,
      input  in_ready, mem_ren, mem_radd, mac_valid, mac_w, mac_x, mac_last
   );
endinterface

// File: rtl/neuron_weight_seq.sv
// Walks one neuron's weight memory, pairing each weight with its activation for the MAC.
// Optional W_SEQ_BIAS_EN appends a bias beat (w = bias, x = FX_ONE) after the last weight.
module neuron_weight_seq
   import fnn_pkg::*;
#(
   parameter int numWeight    = 10,
   parameter int addressWidth = $clog2(numWeight),
   parameter int dataWidth    = FX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [dataWidth-1:0] bias,
   output logic                 busy,
   output logic                 done,
   neuron_weight_seq_if.master  bus
);
   localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

   wseq_state_t             state, state_nxt;
   logic [addressWidth-1:0] radd_q;
   logic [dataWidth-1:0]    x_q;
   logic                    pend_q;
   logic                    done_q;
   logic                    accept;
   logic                    last;

   assign bus.in_ready = (state == S_RUN);
   assign accept       = bus.in_valid & bus.in_ready;
   assign bus.mem_ren  = accept;
   assign bus.mem_radd = radd_q;
   assign busy         = (state != S_IDLE);
   assign done         = done_q;
   assign bus.mac_last = last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (accept && radd_q == LAST_ADDR) state_nxt = S_DRAIN;
`ifdef W_SEQ_BIAS_EN
         S_DRAIN: state_nxt = S_BIAS;
         S_BIAS:  state_nxt = S_IDLE;
`else
         S_DRAIN: state_nxt = S_IDLE;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Data beats pass the memory output straight through; the read lands one cycle after accept.
   always_comb begin
      bus.mac_valid = pend_q;
      bus.mac_w     = bus.mem_wout;
      bus.mac_x     = x_q;
      last          = 1'b0;
`ifdef W_SEQ_BIAS_EN
      if (state == S_BIAS) begin
         bus.mac_valid = 1'b1;
         bus.mac_w     = bias;
         bus.mac_x     = dataWidth'(FX_ONE);
         last          = 1'b1;
      end
`else
      last = (state == S_DRAIN);
`endif
   end

`ifndef W_SEQ_BIAS_EN
   logic bias_unused;
   assign bias_unused = ^bias;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         radd_q <= '0;
         x_q    <= '0;
         pend_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         pend_q <= accept;
         done_q <= last;
         if (state == S_IDLE && start) begin
            radd_q <= '0;
         end else if (accept) begin
            x_q <= bus.in_data;
            // Counter parks on the last address rather than wrapping.
            if (radd_q != LAST_ADDR) radd_q <= radd_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_neuron_weight_seq.sv
// Directed bench for neuron_weight_seq with a behavioural 1-cycle-latency weight memory.
module tb_neuron_weight_seq;
   import fnn_pkg::*;

   localparam int NW = 10;
`ifdef W_SEQ_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif
   localparam int          NBEATS   = NW + (BIAS_EN ? 1 : 0);
   localparam logic [15:0] BIAS_VAL = 16'h0123;
   localparam logic [15:0] ONE      = 16'h0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] bias;
   logic        busy;
   logic        done;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] mem [NW];

   neuron_weight_seq_if #(.addressWidth(4), .dataWidth(16)) bus ();

   neuron_weight_seq #(.numWeight(NW), .addressWidth(4), .dataWidth(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bias  (bias),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.mem_ren) bus.mem_wout <= mem[bus.mem_radd];

   function automatic logic [15:0] exp_w(input int k);
      return 16'h1000 + 16'(k * 17);
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bias = BIAS_VAL;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_wout = '0;
      #2;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
      n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); else n_pass++;
      n_chk++; if (bus.mac_valid !== 1'b0) $display("FAIL reset_mac_valid got %b exp 0", bus.mac_valid); else n_pass++;
      n_chk++; if (bus.mac_last !== 1'b0) $display("FAIL reset_mac_last got %b exp 0", bus.mac_last); else n_pass++;
      n_chk++; if (bus.mem_radd !== 4'd0) $display("FAIL reset_radd got %0d exp 0", bus.mem_radd); else n_pass++;
      tick(); rst = 1'b0; tick();
      bus.in_valid = 1'b1; #1;
      n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL idle_in_ready got %b exp 0", bus.in_ready); else n_pass++;
      n_chk++; if (bus.mem_ren !== 1'b0) $display("FAIL idle_mem_ren got %b exp 0", bus.mem_ren); else n_pass++;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_pass();
      start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'd1; tick(); start = 1'b0;
      for (int p = 1; p <= 4; p++) begin bus.in_data = 16'(p); tick(); end
      #2; rst = 1'b1; #1;
      n_chk++;
      if ({busy, done, bus.in_ready, bus.mem_ren, bus.mac_valid, bus.mac_last, bus.mem_radd} !== 10'd0)
         $display("FAIL midrst_outputs got %b exp 0",
                  {busy, done, bus.in_ready, bus.mem_ren, bus.mac_valid, bus.mac_last, bus.mem_radd});
      else n_pass++;
      tick(); rst = 1'b0;
      for (int p = 0; p < 3; p++) begin
         #1;
         n_chk++;
         if ({busy, done, bus.mac_valid} !== 3'b000)
            $display("FAIL midrst_quiet got %b exp 000", {busy, done, bus.mac_valid});
         else n_pass++;
         tick();
      end
      start = 1'b1; tick(); start = 1'b0; bus.in_data = 16'd1; #1;
      n_chk++; if (bus.mem_radd !== 4'd0) $display("FAIL restart_radd got %0d exp 0", bus.mem_radd); else n_pass++;
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL restart_in_ready got %b exp 1", bus.in_ready); else n_pass++;
      tick(); #1;
      n_chk++; if (bus.mac_valid !== 1'b1) $display("FAIL restart_beat_valid got %b exp 1", bus.mac_valid); else n_pass++;
      n_chk++; if (bus.mac_w !== exp_w(0)) $display("FAIL restart_beat_w got %h exp %h", bus.mac_w, exp_w(0)); else n_pass++;
      n_chk++; if (bus.mac_x !== 16'd1) $display("FAIL restart_beat_x got %h exp 0001", bus.mac_x); else n_pass++;
      rst = 1'b1; bus.in_valid = 1'b0; tick(); rst = 1'b0; tick();
   endtask

   task automatic test_full_pass();
      int done_p;
      logic ev, el;
      done_p = BIAS_EN ? 13 : 12;
      start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'd0; tick(); start = 1'b0;
      for (int p = 1; p <= 14; p++) begin
         bus.in_data = 16'(p); #1;
         n_chk++; if (bus.in_ready !== (p <= NW)) $display("FAIL full_in_ready p%0d got %b", p, bus.in_ready); else n_pass++;
         if (p <= NW) begin
            n_chk++; if (bus.mem_radd !== 4'(p - 1)) $display("FAIL full_radd p%0d got %0d exp %0d", p, bus.mem_radd, p - 1); else n_pass++;
         end
         ev = (p >= 2 && p <= 11) || (BIAS_EN && p == 12);
         n_chk++; if (bus.mac_valid !== ev) $display("FAIL full_valid p%0d got %b exp %b", p, bus.mac_valid, ev); else n_pass++;
         if (ev && p <= 11) begin
            el = (p == 11) && !BIAS_EN;
            n_chk++; if (bus.mac_w !== exp_w(p - 2)) $display("FAIL full_w p%0d got %h exp %h", p, bus.mac_w, exp_w(p - 2)); else n_pass++;
            n_chk++; if (bus.mac_x !== 16'(p - 1)) $display("FAIL full_x p%0d got %h exp %h", p, bus.mac_x, 16'(p - 1)); else n_pass++;
            n_chk++; if (bus.mac_last !== el) $display("FAIL full_last p%0d got %b exp %b", p, bus.mac_last, el); else n_pass++;
         end else if (ev) begin
            n_chk++; if (bus.mac_w !== BIAS_VAL) $display("FAIL bias_w got %h exp %h", bus.mac_w, BIAS_VAL); else n_pass++;
            n_chk++; if (bus.mac_x !== ONE) $display("FAIL bias_x got %h exp %h", bus.mac_x, ONE); else n_pass++;
            n_chk++; if (bus.mac_last !== 1'b1) $display("FAIL bias_last got %b exp 1", bus.mac_last); else n_pass++;
         end
         n_chk++; if (done !== (p == done_p)) $display("FAIL full_done p%0d got %b exp %b", p, done, p == done_p); else n_pass++;
         n_chk++; if (busy !== (p < done_p)) $display("FAIL full_busy p%0d got %b exp %b", p, busy, p < done_p); else n_pass++;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_stall();
      int acc, pk, beats, bias_p, done_p;
      logic pend, run, v, el;
      acc = 0; pk = 0; beats = 0; bias_p = -1; done_p = -1; pend = 1'b0;
      start = 1'b1; bus.in_valid = 1'b0; tick(); start = 1'b0;
      for (int p = 1; p <= 45; p++) begin
         run = (acc < NW);
         v   = ((p - 1) % 3 == 0);
         bus.in_valid = v; bus.in_data = 16'(acc + 1); #1;
         n_chk++; if (bus.mem_ren !== (v && run)) $display("FAIL stall_ren p%0d got %b exp %b", p, bus.mem_ren, v && run); else n_pass++;
         if (run) begin
            n_chk++; if (bus.mem_radd !== 4'(acc)) $display("FAIL stall_radd p%0d got %0d exp %0d", p, bus.mem_radd, acc); else n_pass++;
         end
         n_chk++; if (bus.mac_valid !== (pend || p == bias_p)) $display("FAIL stall_valid p%0d got %b exp %b", p, bus.mac_valid, pend || p == bias_p); else n_pass++;
         if (pend) begin
            el = (pk == NW - 1) && !BIAS_EN;
            n_chk++; if (bus.mac_w !== exp_w(pk)) $display("FAIL stall_w k%0d got %h exp %h", pk, bus.mac_w, exp_w(pk)); else n_pass++;
            n_chk++; if (bus.mac_x !== 16'(pk + 1)) $display("FAIL stall_x k%0d got %h exp %h", pk, bus.mac_x, 16'(pk + 1)); else n_pass++;
            n_chk++; if (bus.mac_last !== el) $display("FAIL stall_last k%0d got %b exp %b", pk, bus.mac_last, el); else n_pass++;
            if (pk == NW - 1) begin
               if (BIAS_EN) begin bias_p = p + 1; done_p = p + 2; end
               else done_p = p + 1;
            end
            beats++;
         end else if (p == bias_p) begin
            n_chk++; if (bus.mac_w !== BIAS_VAL) $display("FAIL stall_bias_w got %h exp %h", bus.mac_w, BIAS_VAL); else n_pass++;
            beats++;
         end
         n_chk++; if (done !== (p == done_p)) $display("FAIL stall_done p%0d got %b exp %b", p, done, p == done_p); else n_pass++;
         pend = v && run;
         if (pend) begin pk = acc; acc++; end
         tick();
      end
      bus.in_valid = 1'b0;
      n_chk++; if (beats !== NBEATS) $display("FAIL stall_beats got %0d exp %0d", beats, NBEATS); else n_pass++;
   endtask

   task automatic test_start_ignored();
      int beats, dones;
      beats = 0; dones = 0;
      start = 1'b1; bus.in_valid = 1'b1; tick(); start = 1'b0;
      for (int p = 1; p <= 16; p++) begin
         start = (p == 3 || p == 7);
         bus.in_data = 16'(p); #1;
         if (bus.mac_valid === 1'b1 && beats < NW) begin
            n_chk++; if (bus.mac_w !== exp_w(beats)) $display("FAIL ign_w k%0d got %h exp %h", beats, bus.mac_w, exp_w(beats)); else n_pass++;
            n_chk++; if (bus.mac_x !== 16'(beats + 1)) $display("FAIL ign_x k%0d got %h exp %h", beats, bus.mac_x, 16'(beats + 1)); else n_pass++;
         end
         if (bus.mac_valid === 1'b1) beats++;
         if (done === 1'b1) dones++;
         tick();
      end
      start = 1'b0; bus.in_valid = 1'b0;
      n_chk++; if (beats !== NBEATS) $display("FAIL ign_beats got %0d exp %0d", beats, NBEATS); else n_pass++;
      n_chk++; if (dones !== 1) $display("FAIL ign_dones got %0d exp 1", dones); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL ign_busy got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int beats;
      bit found;
      found = 1'b0;
      start = 1'b1; bus.in_valid = 1'b1; tick(); start = 1'b0;
      for (int p = 1; p <= 20; p++) begin
         bus.in_data = 16'(p); #1;
         if (done === 1'b1) begin found = 1'b1; break; end
         tick();
      end
      n_chk++; if (!found) $display("FAIL b2b_first_done got timeout exp done"); else n_pass++;
      start = 1'b1; tick(); start = 1'b0;
      bus.in_data = 16'd1; #1;
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); else n_pass++;
      n_chk++; if (bus.mem_radd !== 4'd0) $display("FAIL b2b_radd got %0d exp 0", bus.mem_radd); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b exp 1", busy); else n_pass++;
      beats = 0; found = 1'b0;
      for (int p = 1; p <= 20; p++) begin
         bus.in_data = 16'(p); #1;
         if (bus.mac_valid === 1'b1) begin
            if (beats < NW) begin
               n_chk++; if (bus.mac_w !== exp_w(beats)) $display("FAIL b2b_w k%0d got %h exp %h", beats, bus.mac_w, exp_w(beats)); else n_pass++;
               n_chk++; if (bus.mac_x !== 16'(beats + 1)) $display("FAIL b2b_x k%0d got %h exp %h", beats, bus.mac_x, 16'(beats + 1)); else n_pass++;
            end
            beats++;
         end
         if (done === 1'b1) begin found = 1'b1; break; end
         tick();
      end
      bus.in_valid = 1'b0;
      n_chk++; if (!found) $display("FAIL b2b_second_done got timeout exp done"); else n_pass++;
      n_chk++; if (beats !== NBEATS) $display("FAIL b2b_beats got %0d exp %0d", beats, NBEATS); else n_pass++;
   endtask

   initial begin
      for (int k = 0; k < NW; k++) mem[k] = exp_w(k);
      test_reset();
      test_reset_mid_pass();
      test_full_pass();
      test_stall();
      test_start_ignored();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
